// File: rtl/m1_nibble_driver.sv
// Upstream feeder for M1: takes one cfg/data byte pair per handshake and
// drives it out as two acknowledged nibble beats, aborting on a stalled beat.
//
// state | meaning
// IDLE  | ready for a new transfer, x0 low
// LO    | low nibble on x1, waiting for x2
// HI    | high nibble on x1, waiting for x2
module m1_nibble_driver #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_cfg,
  input  logic [7:0] in_data,
  output logic [7:0] C,
  output logic       x0,
  output logic [3:0] x1,
  input  logic       x2,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    hi_nib, hi_nib_nx;
  logic [7:0]    c_nx;
  logic [3:0]    x1_nx;
  logic          x0_nx, done_nx, err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_nib <= 4'h0;
      C      <= 8'h00;
      x0     <= 1'b0;
      x1     <= 4'h0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      hi_nib <= hi_nib_nx;
      C      <= c_nx;
      x0     <= x0_nx;
      x1     <= x1_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hi_nib_nx = hi_nib;
    c_nx      = C;
    x0_nx     = x0;
    x1_nx     = x1;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          c_nx      = in_cfg;
          x1_nx     = in_data[3:0];
          hi_nib_nx = in_data[7:4];
          x0_nx     = 1'b1;
          cnt_nx    = '0;
          state_nx  = LO;
        end
      end
      LO, HI: begin
        // An ack on the terminal wait cycle still counts as an ack.
        if (x2) begin
          cnt_nx = '0;
          if (state == LO) begin
            x1_nx    = hi_nib;
            state_nx = HI;
          end else begin
            x0_nx    = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else if (cnt == CNT_TC) begin
          x0_nx    = 1'b0;
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

endmodule
